// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner arbiter for a shared 8-way bus mux, with an idle turnaround between owners.
// Optional forced release after MaxHoldCycles granted cycles: define MUX_ARB_TIMEOUT_EN.
module mux8_rr_arbiter #(
  parameter int TurnaroundCycles = 1,
  parameter int MaxHoldCycles    = 256
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Req,
  output logic [7:0] Grant,
  output logic [2:0] Sel,
  output logic       Enable,
  output logic       Busy,
  output logic       Timeout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [3:0] GapLoad = 4'((TurnaroundCycles > 0) ? TurnaroundCycles - 1 : 0);

  if ((TurnaroundCycles < 0) || (TurnaroundCycles > 15) ||
      (MaxHoldCycles < 1) || (MaxHoldCycles > 65535)) begin : gBadParams
    $error("mux8_rr_arbiter: parameter out of legal range");
  end

  // Returns {found, index}; the lowest priority slot is the previous owner itself.
  function automatic logic [3:0] rrPick(input logic [7:0] req, input logic [2:0] last);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int i = 8; i >= 1; i--) begin
      idx = last + 3'(i);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  logic [1:0] stateR, stateS;
  logic [7:0] grantR, grantS;
  logic [2:0] selR, selS;
  logic [2:0] lastR, lastS;
  logic       enableR, enableS;
  logic       busyR, busyS;
  logic [3:0] gapR, gapS;
  logic [3:0] pickS;
  logic       dropS;
  logic       releaseS;
  logic       timeoutS;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [15:0] HoldLimit = 16'(MaxHoldCycles - 1);
  logic [15:0] holdR, holdS;
  logic        expiredS;
  logic        timeoutR;
  assign expiredS = (holdR >= HoldLimit);
  assign releaseS = dropS | expiredS;
  assign timeoutS = expiredS & ~dropS;
  assign Timeout  = timeoutR;
`else
  assign releaseS = dropS;
  assign timeoutS = 1'b0;
  assign Timeout  = 1'b0;
`endif

  assign pickS = rrPick(Req, lastR);
  assign dropS = ~Req[selR];

  // Next-state and next-output computation for the IDLE/OWN/GAP sequence.
  always_comb begin
    stateS  = stateR;
    grantS  = grantR;
    selS    = selR;
    lastS   = lastR;
    enableS = enableR;
    busyS   = busyR;
    gapS    = gapR;
`ifdef MUX_ARB_TIMEOUT_EN
    holdS   = holdR;
`endif
    case (stateR)
      IDLE: begin
        if (pickS[3]) begin
          stateS  = OWN;
          grantS  = 8'b0000_0001 << pickS[2:0];
          selS    = pickS[2:0];
          lastS   = pickS[2:0];
          enableS = 1'b1;
          busyS   = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
          holdS   = 16'd0;
`endif
        end else begin
          stateS = IDLE;
          busyS  = 1'b0;
        end
      end
      OWN: begin
        if (releaseS) begin
          grantS  = 8'b0000_0000;
          enableS = 1'b0;
          if (TurnaroundCycles == 0) begin
            stateS = IDLE;
            busyS  = 1'b0;
          end else begin
            stateS = GAP;
            gapS   = GapLoad;
            busyS  = 1'b1;
          end
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
          holdS = holdR + 16'd1;
`endif
          stateS = OWN;
        end
      end
      GAP: begin
        if (gapR == 4'd0) begin
          stateS = IDLE;
          busyS  = 1'b0;
        end else begin
          gapS = gapR - 4'd1;
        end
      end
      default: begin
        stateS  = IDLE;
        grantS  = 8'b0000_0000;
        enableS = 1'b0;
        busyS   = 1'b0;
        gapS    = 4'd0;
      end
    endcase
  end

  // State and output registers; every output leaves the block from a flop.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stateR   <= IDLE;
      grantR   <= 8'b0000_0000;
      selR     <= 3'd0;
      lastR    <= 3'd7;
      enableR  <= 1'b0;
      busyR    <= 1'b0;
      gapR     <= 4'd0;
`ifdef MUX_ARB_TIMEOUT_EN
      holdR    <= 16'd0;
      timeoutR <= 1'b0;
`endif
    end else begin
      stateR   <= stateS;
      grantR   <= grantS;
      selR     <= selS;
      lastR    <= lastS;
      enableR  <= enableS;
      busyR    <= busyS;
      gapR     <= gapS;
`ifdef MUX_ARB_TIMEOUT_EN
      holdR    <= holdS;
      timeoutR <= (stateR == OWN) ? timeoutS : 1'b0;
`endif
    end
  end

  assign Grant  = grantR;
  assign Sel    = selR;
  assign Enable = enableR;
  assign Busy   = busyR;

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8-way bus multiplexer between 8 requesters.
- Drives the mux's 3-bit Sel and its Enable, plus a one-hot Grant back to the requesters.
- Ownership is held until the owner drops its request. A programmable idle turnaround separates grants, so the shared bus never switches owners while Enable is high.

Parameters:
- TurnaroundCycles, 1: idle cycles with Enable=0 inserted after each release, legal range 0..15.
- MaxHoldCycles, 256: maximum consecutive granted cycles before a forced release, legal range 1..65535. Used only with MUX_ARB_TIMEOUT_EN.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  8  request vector; bit i = requester i. A requester holds its bit high for as long as it uses the bus.
- Grant  out  8  one-hot grant, registered; all zero when no owner.
- Sel  out  3  mux select, registered; index of the current or most recent owner.
- Enable  out  1  mux enable, registered; high exactly when Grant is non-zero.
- Busy  out  1  high in OWN and GAP states.
- Timeout  out  1  one-cycle pulse on a forced release. Tied 0 when the feature is compiled out.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - state=IDLE, Grant=0, Sel=0, Enable=0, Busy=0, Timeout=0.
  - Last=7, so requester 0 has first priority after reset.
  - Gap and hold counters cleared.
- IDLE:
  - If Req==0, stay in IDLE.
  - Otherwise pick winner W = first set bit scanning (Last+1) mod 8 upward, wrapping past 7 to 0.
  - At the next edge: Grant=1<<W, Sel=W, Enable=1, Last=W, state=OWN.
  - Latency: request sampled at edge n produces grant visible after edge n+1 (one cycle).
- OWN:
  - While Req[Sel]=1, hold all outputs. Other requests are ignored and there is no preemption.
  - On Req[Sel]=0 at an edge: Grant=0, Enable=0. Sel keeps its value.
  - Then state=GAP with gap counter=TurnaroundCycles-1, or state=IDLE if TurnaroundCycles=0.
- GAP:
  - Outputs idle and requests ignored.
  - Decrement the counter each cycle; at 0, go to IDLE.
  - The IDLE cycle then arbitrates normally.
- Spacing between grants:
  - Enable is low for at least 1+TurnaroundCycles cycles between two grants when TurnaroundCycles>=1.
  - Enable is low for at least 1 cycle when TurnaroundCycles=0.
- Boundary conditions:
  - A requester that drops and re-raises Req during GAP competes normally in IDLE. Rotation means it loses to any other pending requester.
  - Glitch-free outputs: Grant, Sel and Enable change only at clock edges or asynchronously on Reset.
  - Req bits for non-owners may toggle freely during OWN with no effect.
  - Release and a new request arriving in the same cycle: the release is processed first, and the new request is arbitrated in the IDLE cycle.
  - Busy = (state != IDLE).

Optional Feature:
- Macro: MUX_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit hold counter clears on entry to OWN and increments each OWN cycle.
  - When the owner has held the bus for MaxHoldCycles cycles, the next edge forces a release exactly as if Req[Sel]=0, and Timeout pulses high for that one cycle.
  - Last already points at the preempted owner, so other pending requesters win next.
  - If the preempted owner is the only requester, it is re-granted after the gap.
- Without the macro: no hold counter, Timeout is constant 0, and ownership is unbounded.

Test Plan:
1. Reset, then Req=8'h01 at edge n -> after edge n+1: Grant=8'h01, Sel=0, Enable=1, Busy=1. Drop Req -> Enable=0 for 2 cycles (TurnaroundCycles=1), Busy low after the gap.
2. Req=8'hFF constant; each owner drops its bit for one cycle after 3 granted cycles, then re-raises -> grant order 0,1,2,3,4,5,6,7,0 with Sel matching and Grant always one-hot.
3. Wrap: after owner 2 releases, Req=8'b1000_0001 -> next grant is 7; after 7 releases, grant is 0.
4. Reset asserted mid-OWN with Sel=5 (between edges) -> Grant=0, Enable=0, Sel=0 immediately. After deassert with Req=8'h21 -> grant 0 (Last=7), not 5.
5. TurnaroundCycles=0, owner 3 releases while Req[4]=1 -> exactly one cycle with Enable=0, then Grant=8'h10. TurnaroundCycles=15 -> exactly 16 low cycles.
6. MUX_ARB_TIMEOUT_EN with MaxHoldCycles=4, Req=8'h03 held -> grant 0 for 4 cycles, a 1-cycle Timeout pulse, then grant 1. With Req=8'h01 only -> grant 0, timeout, gap, then grant 0 again.
